// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Brief   : ALU function codes, illegal-result constant, legal-code check.
// Rev     : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1001;

  localparam logic [31:0] ALU_ILLEGAL_RESULT = 32'hDEADBEEF;

  function automatic logic alu_fun_legal(input logic [3:0] fun);
    logic ok;
    case (fun)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_arbiter_if
// Brief     : One requester channel: request handshake plus response slot.
// Rev       : 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_srcA;
  logic [WIDTH-1:0] req_srcB;
  logic [3:0]       req_fun;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req_valid, req_srcA, req_srcB, req_fun, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_srcA, req_srcB, req_fun, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : alu_rr_arb2
// Brief  : Two-way round-robin grant; a tie goes to the requester not granted last.
// Rev    : 1.0
// ============================================================================
module alu_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic elig0,
  input  logic elig1,
  output logic grant0,
  output logic grant1
);
  // r_last_grant = 1 means requester 1 was granted most recently
  logic r_last_grant;

  assign grant0 = elig0 && (!elig1 || r_last_grant);
  assign grant1 = elig1 && (!elig0 || !r_last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (grant0) begin
      r_last_grant <= 1'b0;
    end else if (grant1) begin
      r_last_grant <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Brief  : Shares one combinational ALU between two requesters with response slots.
//          Optional macro ALU_ARB_ILLEGAL_CHK_EN enables illegal fun-code flagging.
// Rev    : 1.0
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     ch0,
  alu_arbiter_if.slave     ch1,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_result
);
  logic             w_elig0, w_elig1;
  logic             w_grant0, w_grant1;
  logic             w_illegal;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_result, r_rsp1_result;
  logic             r_rsp0_err, r_rsp1_err;

  // A slot draining this cycle can accept a new result on the same edge
  assign w_elig0 = ch0.req_valid && (!r_rsp0_valid || ch0.rsp_ready);
  assign w_elig1 = ch1.req_valid && (!r_rsp1_valid || ch1.rsp_ready);

  alu_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig0  (w_elig0),
    .elig1  (w_elig1),
    .grant0 (w_grant0),
    .grant1 (w_grant1)
  );

  assign ch0.req_ready  = w_grant0;
  assign ch1.req_ready  = w_grant1;
  assign ch0.rsp_valid  = r_rsp0_valid;
  assign ch1.rsp_valid  = r_rsp1_valid;
  assign ch0.rsp_result = r_rsp0_result;
  assign ch1.rsp_result = r_rsp1_result;
  assign ch0.rsp_err    = r_rsp0_err;
  assign ch1.rsp_err    = r_rsp1_err;

  always_comb begin
    alu_srcA = '0;
    alu_srcB = '0;
    alu_fun  = ALU_ADD;
    if (w_grant0) begin
      alu_srcA = ch0.req_srcA;
      alu_srcB = ch0.req_srcB;
      alu_fun  = ch0.req_fun;
    end else if (w_grant1) begin
      alu_srcA = ch1.req_srcA;
      alu_srcB = ch1.req_srcB;
      alu_fun  = ch1.req_fun;
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign w_illegal = !alu_fun_legal(alu_fun);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_err    <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= alu_result;
      r_rsp0_err    <= w_illegal;
    end else if (ch0.rsp_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_err    <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= alu_result;
      r_rsp1_err    <= w_illegal;
    end else if (ch1.rsp_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (req0: execute stage, req1: the multi-cycle address/CSR helper) using valid/ready handshakes. Each cycle it grants at most one requester, drives that requester's operands onto the ALU, and captures the ALU result into that requester's response register. It sits between the datapath stages and the ALU instance. It owns all sequencing of ALU access, including round-robin fairness and backpressure.

## Interface
- WIDTH, 32, operand/result width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- reqN_valid  input  1  requester N (N=0,1) has an operation
- reqN_ready  output  1  requester N's operation is accepted this cycle
- reqN_srcA, reqN_srcB  input  WIDTH  operands
- reqN_fun  input  4  ALU function code
- rspN_valid  output  1  result pending for requester N
- rspN_ready  input  1  requester N consumes the result
- rspN_result  output  WIDTH  registered ALU result
- rspN_err  output  1  result came from an illegal function code (see Configuration)
- alu_srcA, alu_srcB  output  WIDTH  to ALU
- alu_fun  output  4  to ALU
- alu_result  input  WIDTH  from ALU (combinational)

## Operation
- Eligibility:
  - eligN = reqN_valid && (!rspN_valid || rspN_ready).
  - A requester has at most one outstanding result.
  - A slot being drained this cycle may be refilled in the same cycle.
- Arbitration:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one NOT granted most recently.
  - last_grant updates only when a grant occurs.
  - Reset value of last_grant is 1, so req0 wins the first tie.
- reqN_ready = grantN. This is combinational from valid and response state, with no dependency on operand values.
- ALU drive:
  - Granted: alu_* = granted requester's srcA/srcB/fun.
  - No grant: alu_srcA=0, alu_srcB=0, alu_fun=4'b0000.
- Capture on the edge ending a grant cycle:
  - rspN_result <= alu_result, rspN_valid <= 1, rspN_err per Configuration.
- Drain: rspN_valid && rspN_ready with no new grant clears rspN_valid. rspN_result holds its last value.
- A simultaneous drain and grant of the same requester leaves rspN_valid=1 with the new result.
- The two response slots are independent. A stalled rsp1 never blocks req0.
- Reset (asynchronous, any time) clears the following:
  - rspN_valid=0, rspN_result=0, rspN_err=0, last_grant=1.
  - In-flight results are dropped. reqN_ready and alu_* follow from the cleared state.

## Timing
- Latency: request accepted in cycle T gives rspN_valid=1 and the result in cycle T+1.
- Throughput: one op per cycle total. A single requester alone with rspN_ready held high sustains 1 op/cycle.
- Both requesters continuously valid with ready responses: grants alternate 0,1,0,1.
- Requester obligations, checked by assertions in the bench:
  - While reqN_valid=1 and reqN_ready=0, reqN_srcA/srcB/fun stay stable and valid stays high.
  - rspN_result and rspN_err are stable while rspN_valid=1 and rspN_ready=0.

## Configuration
- ALU_ARB_ILLEGAL_CHK_EN:
  - Defined: a combinational decoder flags fun codes outside the legal set {0000,1000,0110,0111,0100,0101,0001,1101,0010,0011,1001}. The flag is registered into rspN_err alongside the result. The result value is still whatever the ALU returns (32'hDEADBEEF for illegal codes).
  - Undefined: the decoder is not built and rspN_err is tied 0. All other behaviour is identical.

## Structure
- Shared package (alu_pkg):
  - ALU function-code constants (ALU_ADD=4'b0000, ALU_SUB=4'b1000, … ALU_LUI=4'b1001).
  - Legal-code check function.
  - ALU_ILLEGAL_RESULT=32'hDEADBEEF.
- One sub-module, alu_rr_arb2: 2-way round-robin grant logic with last_grant register. Inputs elig0/elig1, outputs grant0/grant1.
- The top level holds the muxing and response registers.

## Test plan
- Single op: req0 {srcA=5, srcB=7, fun=0000} with rsp0_ready=1 -> req0_ready=1 in T; rsp0_valid=1, rsp0_result=12 in T+1.
- Tie after reset: both valid in the same cycle (req0 SUB 10-3, req1 SLT -1<1) -> req0 granted first (result 7), then req1 the next cycle (result 1). Continued contention alternates grants.
- Backpressure: rsp1_ready=0 with rsp1 pending, req1 valid -> req1_ready=0 and rsp1_result held. req0 still completes every cycle. Raising rsp1_ready allows the same-cycle drain+regrant.
- Illegal code: req0 fun=4'b1111 -> rsp0_result=32'hDEADBEEF. rsp0_err=1 with ALU_ARB_ILLEGAL_CHK_EN defined, 0 without.
- Reset mid-operation: assert rst while rsp0_valid=1 and req1 is being granted -> rsp0_valid, rsp1_valid and rspN_err drop immediately (asynchronously). After release, the next tie grants req0.
- Idle: no valids -> alu_fun=0000, alu_srcA=alu_srcB=0, and no rsp_valid ever asserts.
